// File: rtl/n37_err_sched_if.sv
// Frame handshake, decoder-mux and fix-write bus of the error scheduler.
// The master side issues frames and supplies decoded messages; the slave side is the scheduler.
interface n37_err_sched_if #(
  parameter int ROWS  = 6,
  parameter int COLS  = 6,
  parameter int MSG_W = 13
);
  logic                 start;
  logic [ROWS*COLS-1:0] err_flags;
  logic [MSG_W-1:0]     dec_message;
  logic [5:0]           sel;
  logic                 sel_valid;
  logic                 fix_we;
  logic [5:0]           fix_idx;
  logic [MSG_W-1:0]     fix_data;
  logic                 busy;
  logic                 done;
  logic [5:0]           fix_count;
  logic                 uncorrectable;

  modport master (
    output start, err_flags, dec_message,
    input  sel, sel_valid, fix_we, fix_idx, fix_data, busy, done, fix_count, uncorrectable
  );
  modport slave (
    input  start, err_flags, dec_message,
    output sel, sel_valid, fix_we, fix_idx, fix_data, busy, done, fix_count, uncorrectable
  );
endinterface

// File: rtl/n37_err_sched.sv
// Row/column error-intersection scheduler: latches per-cell error flags, expands them to
// candidate cells, and streams one corrected message per cycle to the output register file.
module n37_err_sched #(
  parameter int ROWS    = 6,
  parameter int COLS    = 6,
  parameter int MSG_W   = 13,
  parameter int MAX_FIX = 6
) (
  input logic             clk,
  input logic             rst_n,
  n37_err_sched_if.slave  bus
);
  localparam int N = ROWS * COLS;

  typedef enum logic [1:0] {IDLE, SCAN, FIX, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   flag_q, flag_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [5:0]     fix_count_q, fix_count_d;
  logic           uncorr_q, uncorr_d;

  logic [ROWS-1:0] er;
  logic [COLS-1:0] ec;
  logic [N-1:0]    cand;
  logic [5:0]      cnt;
  logic [5:0]      low_idx;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign er[r] = |flag_q[r*COLS +: COLS];
    for (genvar c = 0; c < COLS; c++) begin : g_cell
      assign cand[r*COLS + c] = er[r] & ec[c];
    end
  end

  always_comb begin
    ec = '0;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        ec[c] = ec[c] | flag_q[r*COLS + c];
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) cnt = cnt + 6'(cand[i]);
  end

  // Descending scan so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (mask_q[i]) low_idx = 6'(i);
  end

  always_comb begin
    state_d       = state_q;
    flag_d        = flag_q;
    mask_d        = mask_q;
    fix_count_d   = fix_count_q;
    uncorr_d      = uncorr_q;
    bus.sel       = '0;
    bus.sel_valid = 1'b0;
    bus.fix_we    = 1'b0;
    bus.fix_idx   = '0;
    bus.fix_data  = '0;
    case (state_q)
      IDLE: if (bus.start) begin
        flag_d      = bus.err_flags;
        fix_count_d = '0;
        uncorr_d    = 1'b0;
        state_d     = SCAN;
      end
      SCAN: begin
        if (cnt == '0) begin
          state_d = DONE;
        end else if (cnt > 6'(MAX_FIX)) begin
          uncorr_d = 1'b1;
          state_d  = DONE;
        end else begin
          mask_d  = cand;
          state_d = FIX;
        end
      end
      FIX: begin
        bus.sel       = low_idx;
        bus.sel_valid = 1'b1;
        bus.fix_we    = 1'b1;
        bus.fix_idx   = low_idx;
        bus.fix_data  = bus.dec_message;
        mask_d        = mask_q & ~(N'(1) << low_idx);
        fix_count_d   = fix_count_q + 6'd1;
        if (mask_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);
  assign bus.fix_count     = fix_count_q;
  assign bus.uncorrectable = uncorr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flag_q      <= '0;
      mask_q      <= '0;
      fix_count_q <= '0;
      uncorr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flag_q      <= flag_d;
      mask_q      <= mask_d;
      fix_count_q <= fix_count_d;
      uncorr_q    <= uncorr_d;
    end
  end
endmodule

// File: tb/tb_n37_err_sched.sv
// Directed and randomized frames against a candidate-list model of the scheduler.
module tb_n37_err_sched;
  localparam int ROWS = 6, COLS = 6, MSG_W = 13, MAX_FIX = 6, N = ROWS * COLS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  n37_err_sched_if #(.ROWS(ROWS), .COLS(COLS), .MSG_W(MSG_W)) bus ();

  n37_err_sched #(.ROWS(ROWS), .COLS(COLS), .MSG_W(MSG_W), .MAX_FIX(MAX_FIX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Candidate set: every cell whose row and column each contain at least one flagged cell.
  function automatic void model(input logic [N-1:0] f);
    bit row_hit[ROWS];
    bit col_hit[COLS];
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) row_hit[r] = 0;
    for (int c = 0; c < COLS; c++) col_hit[c] = 0;
    for (int i = 0; i < N; i++)
      if (f[i]) begin
        row_hit[i / COLS] = 1;
        col_hit[i % COLS] = 1;
      end
    for (int i = 0; i < N; i++)
      if (row_hit[i / COLS] && col_hit[i % COLS]) exp_q.push_back(i);
  endfunction

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".fix_we"},    32'(bus.fix_we), 0);
    chk({tag, ".sel_valid"}, 32'(bus.sel_valid), 0);
    chk({tag, ".sel"},       32'(bus.sel), 0);
    chk({tag, ".fix_idx"},   32'(bus.fix_idx), 0);
    chk({tag, ".fix_data"},  32'(bus.fix_data), 0);
  endtask

  // Called at posedge+1. repulse_cyc: cycle in which start is pulsed again (0 = never).
  task automatic run_frame(input string tag, input logic [N-1:0] f, input int repulse_cyc);
    int k, nw, dc;
    bit unc;
    logic [MSG_W-1:0] dec;
    model(f);
    k   = exp_q.size();
    unc = (k > MAX_FIX);
    nw  = unc ? 0 : k;
    dc  = nw + 2;
    bus.start     = 1'b1;
    bus.err_flags = f;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.err_flags = N'({$urandom, $urandom});
    for (int c = 1; c <= dc; c++) begin
      dec = MSG_W'($urandom);
      bus.dec_message = dec;
      if (c == repulse_cyc) bus.start = 1'b1;
      #1;
      chk({tag, ".busy"}, 32'(bus.busy), 1);
      chk({tag, ".done"}, 32'(bus.done), 32'(c == dc));
      if (c == 1) chk({tag, ".unc_clr"}, 32'(bus.uncorrectable), 0);
      if (c >= 2 && c <= nw + 1) begin
        chk({tag, ".fix_we"},    32'(bus.fix_we), 1);
        chk({tag, ".sel_valid"}, 32'(bus.sel_valid), 1);
        chk({tag, ".sel"},       32'(bus.sel), 32'(exp_q[c-2]));
        chk({tag, ".fix_idx"},   32'(bus.fix_idx), 32'(exp_q[c-2]));
        chk({tag, ".fix_data"},  32'(bus.fix_data), 32'(dec));
      end else begin
        chk_idle_outs(tag);
      end
      if (c == dc) begin
        chk({tag, ".fix_count"}, 32'(bus.fix_count), 32'(nw));
        chk({tag, ".unc"},       32'(bus.uncorrectable), 32'(unc));
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    #1;
    chk({tag, ".post_busy"}, 32'(bus.busy), 0);
    chk({tag, ".post_done"}, 32'(bus.done), 0);
    @(posedge clk); #1;
    chk({tag, ".hold_busy"}, 32'(bus.busy), 0);
    chk({tag, ".hold_cnt"},  32'(bus.fix_count), 32'(nw));
    chk({tag, ".hold_unc"},  32'(bus.uncorrectable), 32'(unc));
  endtask

  initial begin
    logic [N-1:0] f;
    bus.start       = 1'b0;
    bus.err_flags   = '0;
    bus.dec_message = '0;

    #2;
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.fix_count", 32'(bus.fix_count), 0);
    chk("rst.unc", 32'(bus.uncorrectable), 0);
    chk_idle_outs("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame("single14", N'(1) << 14, 0);
    run_frame("clean", '0, 0);
    run_frame("two_0_7", (N'(1) << 0) | (N'(1) << 7), 0);
    run_frame("uncorr", (N'(1) << 0) | (N'(1) << 7) | (N'(1) << 14) | (N'(1) << 21), 0);
    run_frame("after_unc", N'(1) << 35, 0);
    run_frame("repulse_fix", (N'(1) << 0) | (N'(1) << 7), 3);
    run_frame("repulse_done", N'(1) << 20, 3);

    // Async reset during the second FIX cycle of a 4-candidate frame.
    bus.start = 1'b1;
    bus.err_flags = (N'(1) << 0) | (N'(1) << 7);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("rstfix.first_we", 32'(bus.fix_we), 1);
    @(posedge clk); #1;
    chk("rstfix.second_we", 32'(bus.fix_we), 1);
    rst_n = 1'b0;
    #1;
    chk("rstfix.busy", 32'(bus.busy), 0);
    chk("rstfix.cnt", 32'(bus.fix_count), 0);
    chk_idle_outs("rstfix");
    @(posedge clk); #1;
    chk("rstfix.no_done", 32'(bus.done), 0);
    chk("rstfix.no_we", 32'(bus.fix_we), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame("post_rst", (N'(1) << 9) | (N'(1) << 16), 0);

    for (int t = 0; t < 25; t++) begin
      f = '0;
      for (int j = $urandom_range(0, 3); j > 0; j--) f[$urandom_range(0, N - 1)] = 1'b1;
      run_frame("rand", f, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
